pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch sequencer that owns the program counter of the 31-instruction MIPS core. It issues word fetches to instruction memory over a req/ack handshake, presents each fetched instruction to the decode/execute stage over a valid/ready handshake, and computes the next PC from the control decision returned when the instruction is accepted: sequential, branch, jump or jump-register. It also handles reset, halt and misaligned jump-register targets, and keeps a retired-instruction count.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- EXC_PC, 32'h0040_0004, PC loaded when a jr target is misaligned.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- imem_req  out  1  fetch request; high exactly while in FETCH.
- imem_addr  out  32  fetch address; equals pc, stable while imem_req=1.
- imem_ack  in  1  memory has imem_rdata valid this cycle; honoured only in FETCH.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/instr_pc valid; high exactly while in ISSUE.
- instr_ready  in  1  consumer accepts instruction this cycle.
- instr  out  32  latched instruction.
- instr_pc  out  32  address of instr.
- br_taken  in  1  accepted instruction is a taken branch.
- br_off  in  16  branch immediate.
- jmp  in  1  accepted instruction is j/jal.
- jmp_idx  in  26  jump index.
- jr  in  1  accepted instruction is jr.
- jr_target  in  32  register value for jr.
- halt  in  1  accepted instruction halts the core.
- addr_err  out  1  one-cycle pulse: misaligned jr target.
- halted  out  1  high while in HALT.
- retire_cnt  out  32  instructions accepted since reset.

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- Reset (rst=1 at an edge), from any state: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, retire_cnt=0, addr_err=0. All outputs derive from these values: imem_req=0, instr_valid=0, halted=0, imem_addr=RESET_PC.
- IDLE: goes to FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, go to ISSUE.
  - Otherwise stay; the address must not change.
- ISSUE: instr_valid=1. Control inputs are sampled only when instr_valid and instr_ready are both high (acceptance).
  - On acceptance: retire_cnt increments, wrapping at 2^32.
  - If halt=1, go to HALT; pc is unchanged.
  - Otherwise pc<=next_pc and go to FETCH.
  - Without instr_ready: stay; instr and instr_pc hold.
- next_pc priority is jr > jmp > br_taken > sequential, with s = instr_pc + 4 (mod 2^32):
  - jr: jr_target if jr_target[1:0]==0; else EXC_PC, with addr_err=1 for the following cycle.
  - jmp: {s[31:28], jmp_idx, 2'b00}.
  - br_taken: s + ({{14{br_off[15]}}, br_off, 2'b00}), mod 2^32.
  - none: s.
- HALT: halted=1; no requests are issued. The block leaves HALT only through rst.
- imem_ack outside FETCH is ignored. Control inputs outside acceptance are ignored.
- addr_err is registered. It is high exactly one cycle, the cycle after the acceptance that raised it, and 0 at all other times.

## Timing
- All outputs are registered or decoded from state and registers; there is no combinational path from any input to any output.
- After rst deasserts: 1 cycle in IDLE, then imem_req rises.
- Zero-wait memory (ack in the first FETCH cycle) with instr_ready tied high: FETCH and ISSUE alternate, giving 1 instruction per 2 cycles.
- Latency from imem_ack to instr_valid is 1 cycle. Latency from acceptance to the next imem_req is 1 cycle, and imem_addr already shows the new pc in that cycle.
- rst during FETCH: imem_req is 0 in the next cycle, and any ack then arriving is ignored. The memory system must tolerate an abandoned request.
- rst in the same cycle as acceptance: rst wins and retire_cnt=0.

## Test plan
- Reset and sequential flow: rst 2 cycles, memory acks immediately, instr_ready=1. Required: first imem_addr=0x00400000, then 0x00400004 and 0x00400008, with instr_valid every other cycle and retire_cnt=3 after 3 acceptances.
- Branch: accept at instr_pc=0x00400010 with br_taken=1, br_off=16'hFFFC. Required: next imem_addr=0x00400004. Repeat with br_off=16'h0003: required 0x00400020.
- Jump and priority: instr_pc=0x00400000, jmp_idx=26'h0100040 → 0x00400100. Then assert jr=1 (jr_target=0x00400200), jmp=1 and br_taken=1 together → 0x00400200.
- Misaligned jr: jr_target=0x00400202. Required: addr_err high exactly 1 cycle and next imem_addr=0x00400004 (EXC_PC).
- Backpressure and wait states: imem_ack delayed 3 cycles with instr_ready low 4 cycles. Required: imem_addr stable throughout, instr and instr_pc stable while instr_valid, retire_cnt unchanged until acceptance, and ack while in ISSUE ignored.
- Halt and reset: accept with halt=1. Required: halted=1, no imem_req for 10 cycles, and retire_cnt incremented once. Then rst for 1 cycle: halted=0 and a fetch from 0x00400000. Also assert rst mid-FETCH: required imem_req=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter owner for the MIPS core: fetches words over req/ack, issues them over
// valid/ready, and steers the PC from the branch/jump/jr/halt decision at acceptance.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_PC   = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        br_taken,
  input  logic [15:0] br_off,
  input  logic        jmp,
  input  logic [25:0] jmp_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        addr_err,
  output logic        halted,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] retire_cnt_q;
  logic        addr_err_q;

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] next_pc;
  logic        jr_misaligned;
  logic        accept;

  assign accept        = (state_q == StIssue) && instr_ready;
  assign jr_misaligned = (jr_target[1:0] != 2'b00);

  always_comb begin
    seq_pc  = instr_pc_q + 32'd4;
    br_pc   = seq_pc + {{14{br_off[15]}}, br_off, 2'b00};
    next_pc = seq_pc;
    if (jr) begin
      next_pc = jr_misaligned ? EXC_PC : jr_target;
    end else if (jmp) begin
      next_pc = {seq_pc[31:28], jmp_idx, 2'b00};
    end else if (br_taken) begin
      next_pc = br_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      instr_pc_q   <= 32'd0;
      retire_cnt_q <= 32'd0;
      addr_err_q   <= 1'b0;
    end else begin
      addr_err_q <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (imem_ack) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (accept) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
            if (halt) begin
              state_q <= StHalt;
            end else begin
              pc_q       <= next_pc;
              addr_err_q <= jr && jr_misaligned;
              state_q    <= StFetch;
            end
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StIssue);
  assign halted      = (state_q == StHalt);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign retire_cnt  = retire_cnt_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle-level reference model checked every cycle,
// plus literal expectations on fetch addresses, counts and the error pulse.
module tb_pc_sequencer;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam logic [31:0] ExcPc   = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        br_taken = 1'b0;
  logic [15:0] br_off = 16'd0;
  logic        jmp = 1'b0;
  logic [25:0] jmp_idx = 26'd0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic        halt = 1'b0;
  logic        addr_err;
  logic        halted;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RESET_PC(ResetPc), .EXC_PC(ExcPc)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .br_taken(br_taken), .br_off(br_off), .jmp(jmp),
    .jmp_idx(jmp_idx), .jr(jr), .jr_target(jr_target), .halt(halt), .addr_err(addr_err),
    .halted(halted), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 fetch, 2 issue, 3 halted.
  int          m_phase;
  bit          m_init;
  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
  logic        m_err;

  function automatic logic [31:0] model_next(input logic [31:0] ipc);
    logic [31:0] s;
    shortint     so;
    int          off;
    s = ipc + 32'd4;
    if (jr) return (jr_target % 4 == 0) ? jr_target : ExcPc;
    if (jmp) return (s & 32'hF000_0000) + {6'd0, jmp_idx} * 32'd4;
    if (br_taken) begin
      so  = br_off;
      off = so;
      return s + 32'(off * 4);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init  <= 1'b1;
      m_phase <= 0;
      m_pc    <= ResetPc;
      m_instr <= 32'd0;
      m_ipc   <= 32'd0;
      m_cnt   <= 32'd0;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_phase == 0) m_phase <= 1;
      else if (m_phase == 1 && imem_ack) begin
        m_instr <= imem_rdata;
        m_ipc   <= m_pc;
        m_phase <= 2;
      end else if (m_phase == 2 && instr_ready) begin
        m_cnt <= m_cnt + 32'd1;
        if (halt) m_phase <= 3;
        else begin
          m_pc    <= model_next(m_ipc);
          m_err   <= jr && (jr_target % 4 != 0);
          m_phase <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
      check("imem_addr", imem_addr, m_pc);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == 2});
      check("halted", {31'd0, halted}, {31'd0, m_phase == 3});
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
      check("addr_err", {31'd0, addr_err}, {31'd0, m_err});
      check("retire_cnt", retire_cnt, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic fetch(input int dly, input logic [31:0] data, input logic [31:0] exp_addr,
                       input string name);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check({name, "_req_seen"}, {31'd0, imem_req}, 32'd1);
    check(name, imem_addr, exp_addr);
    repeat (dly) begin
      step();
      check({name, "_hold"}, imem_addr, exp_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic issue(input int rdly, input logic b, input logic [15:0] off, input logic j,
                       input logic [25:0] idx, input logic r, input logic [31:0] tgt,
                       input logic h);
    int n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    check("issue_valid_seen", {31'd0, instr_valid}, 32'd1);
    repeat (rdly) step();
    instr_ready = 1'b1;
    br_taken = b; br_off = off; jmp = j; jmp_idx = idx; jr = r; jr_target = tgt; halt = h;
    step();
    instr_ready = 1'b0;
    br_taken = 1'b0; jmp = 1'b0; jr = 1'b0; halt = 1'b0;
  endtask

  task automatic seq_issue();
    issue(0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic jr_issue(input logic [31:0] tgt);
    issue(0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, tgt, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(2);
    check("idle_after_reset", {31'd0, imem_req}, 32'd0);
    check("reset_addr", imem_addr, 32'h0040_0000);

    // Sequential flow, zero-wait memory.
    fetch(0, 32'h1111_0000, 32'h0040_0000, "seq0"); seq_issue();
    fetch(0, 32'h1111_0004, 32'h0040_0004, "seq1"); seq_issue();
    fetch(0, 32'h1111_0008, 32'h0040_0008, "seq2"); seq_issue();
    check("retire_after_3", retire_cnt, 32'd3);

    // Backward then forward branch from 0x00400010.
    fetch(0, 32'h2222_000C, 32'h0040_000C, "seq3"); seq_issue();
    fetch(0, 32'h2222_0010, 32'h0040_0010, "br_src"); 
    issue(0, 1'b1, 16'hFFFC, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
    fetch(0, 32'h2222_0004, 32'h0040_0004, "br_back"); jr_issue(32'h0040_0010);
    fetch(0, 32'h2222_0010, 32'h0040_0010, "jr_to_10");
    issue(0, 1'b1, 16'h0003, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
    fetch(0, 32'h3333_0020, 32'h0040_0020, "br_fwd"); jr_issue(32'h0040_0000);

    // Jump, then jr winning over jmp and branch.
    fetch(0, 32'h4444_0000, 32'h0040_0000, "jr_to_0");
    issue(0, 1'b0, 16'd0, 1'b1, 26'h0100040, 1'b0, 32'd0, 1'b0);
    fetch(0, 32'h4444_0100, 32'h0040_0100, "jmp_dst");
    issue(0, 1'b1, 16'h0040, 1'b1, 26'h0000001, 1'b1, 32'h0040_0200, 1'b0);
    fetch(0, 32'h4444_0200, 32'h0040_0200, "prio_jr");

    // Misaligned jr.
    jr_issue(32'h0040_0202);
    check("addr_err_pulse", {31'd0, addr_err}, 32'd1);
    check("exc_addr", imem_addr, 32'h0040_0004);
    step();
    check("addr_err_drop", {31'd0, addr_err}, 32'd0);
    check("retire_after_11", retire_cnt, 32'd11);

    // Wait states, backpressure, and an ack arriving during ISSUE.
    fetch(3, 32'hCAFE_0004, 32'h0040_0004, "slow_fetch");
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      check("bp_instr", instr, 32'hCAFE_0004);
      check("bp_instr_pc", instr_pc, 32'h0040_0004);
      check("bp_retire", retire_cnt, 32'd11);
      step();
    end
    imem_ack = 1'b0;
    check("bp_instr_late", instr, 32'hCAFE_0004);
    seq_issue();
    check("retire_after_bp", retire_cnt, 32'd12);

    // Halt: no requests, even with ack toggling.
    fetch(0, 32'h0000_000D, 32'h0040_0008, "pre_halt");
    issue(0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b1);
    check("halted", {31'd0, halted}, 32'd1);
    check("retire_halt", retire_cnt, 32'd13);
    for (int i = 0; i < 10; i++) begin
      imem_ack = i[0];
      check("halt_no_req", {31'd0, imem_req}, 32'd0);
      step();
    end
    imem_ack = 1'b0;
    do_reset(1);
    check("halt_cleared", {31'd0, halted}, 32'd0);
    check("retire_cleared", retire_cnt, 32'd0);
    fetch(0, 32'h5555_0000, 32'h0040_0000, "post_halt");

    // Reset landing on an acceptance.
    while (!instr_valid) step();
    instr_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    instr_ready = 1'b0;
    check("rst_beats_accept", retire_cnt, 32'd0);

    // Reset mid-FETCH; a late ack must be ignored.
    while (!imem_req) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_fetch", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    check("late_ack_ignored", instr, 32'd0);
    fetch(0, 32'h6666_0000, 32'h0040_0000, "refetch");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
